// File: rtl/ringbuffer_level_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ringbuffer_level_pkg
// Description : Shared ring-buffer constants: drop-counter width, overwrite
//               mode encodings and the strobe-combination encoding used by
//               the level tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package ringbuffer_level_pkg;

    // Width of the saturating dropped-write counter.
    localparam int DROP_COUNT_W = 8;

    // Overwrite mode encodings for the OVERWRITE parameter.
    localparam int OVERWRITE_DROP   = 0;   // discard a write that hits a full buffer
    localparam int OVERWRITE_OLDEST = 1;   // replace the oldest entry instead

    // {write_done, read_done} combination seen in a cycle.
    typedef enum logic [1:0] {
        EV_IDLE  = 2'b00,
        EV_READ  = 2'b01,
        EV_WRITE = 2'b10,
        EV_BOTH  = 2'b11
    } strobe_ev_t;

endpackage : ringbuffer_level_pkg
`default_nettype wire

// File: rtl/ringbuffer_level_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value.
//               Ports:
//                 clk    - rising-edge clock
//                 reset  - asynchronous active-low reset (count -> 0)
//                 inc    - count one event this cycle
//                 clear  - synchronous clear, wins over inc
//                 count  - current count, WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/ringbuffer_level.sv
`default_nettype none
// ============================================================================
// Module      : ringbuffer_level
// Description : Pointer and fill-level tracker for a 2**BITS entry ring
//               buffer, with status flags and a dropped-write counter.
//               Ports:
//                 clk         - rising-edge clock
//                 reset       - asynchronous active-low reset
//                 write_done  - one entry written at write_addr (per cycle)
//                 read_done   - one entry consumed at read_addr (per cycle)
//                 flush       - synchronous clear, overrides both strobes
//                 write_addr  - next slot to write            (BITS)
//                 read_addr   - oldest valid slot             (BITS)
//                 level       - valid entries 0..2**BITS      (BITS+1)
//                 empty/full/almost_full - decodes of level
//                 overflow    - sticky, write seen while full (alone)
//                 underflow   - sticky, read seen while empty
//                 drop_count  - saturating count of writes hitting full
// Revision    : 1.0 - initial release
// ============================================================================
module ringbuffer_level
    import ringbuffer_level_pkg::*;
#(
    parameter int BITS        = 7,
    parameter int ALMOST_FULL = 2**BITS - 4,
    parameter int OVERWRITE   = OVERWRITE_DROP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_done,
    input  logic                    read_done,
    input  logic                    flush,
    output logic [BITS-1:0]         write_addr,
    output logic [BITS-1:0]         read_addr,
    output logic [BITS:0]           level,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    overflow,
    output logic                    underflow,
    output logic [DROP_COUNT_W-1:0] drop_count
);

    localparam logic [BITS:0]   c_depth       = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0]   c_almost_full = (BITS+1)'(ALMOST_FULL);
    localparam logic [BITS:0]   c_lvl_one     = (BITS+1)'(1);
    localparam logic [BITS-1:0] c_ptr_one     = BITS'(1);

    logic [BITS-1:0] r_write_addr, w_write_addr_nxt;
    logic [BITS-1:0] r_read_addr,  w_read_addr_nxt;
    logic [BITS:0]   r_level,      w_level_nxt;
    logic            r_overflow,   w_overflow_nxt;
    logic            r_underflow,  w_underflow_nxt;

    logic            w_overwrite;
    logic            w_empty;
    logic            w_full;
    logic            w_drop;
    strobe_ev_t      w_ev;

    // Overwrite behaviour is fixed at elaboration time.
    generate
        if (OVERWRITE == OVERWRITE_OLDEST) begin : g_ow_oldest
            assign w_overwrite = 1'b1;
        end else begin : g_ow_drop
            assign w_overwrite = 1'b0;
        end
    endgenerate

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_depth);
    assign w_ev    = strobe_ev_t'({write_done, read_done});

    // Only a lone write into a full buffer counts as a drop; a paired
    // read makes room, so that case is accepted normally.
    assign w_drop  = (w_ev == EV_WRITE) && w_full && !flush;

    always_comb begin
        w_write_addr_nxt = r_write_addr;
        w_read_addr_nxt  = r_read_addr;
        w_level_nxt      = r_level;
        w_overflow_nxt   = r_overflow;
        w_underflow_nxt  = r_underflow;

        if (flush) begin
            w_write_addr_nxt = '0;
            w_read_addr_nxt  = '0;
            w_level_nxt      = '0;
            w_overflow_nxt   = 1'b0;
            w_underflow_nxt  = 1'b0;
        end else begin
            case (w_ev)
                EV_WRITE: begin
                    if (!w_full) begin
                        w_write_addr_nxt = r_write_addr + c_ptr_one;
                        w_level_nxt      = r_level + c_lvl_one;
                    end else begin
                        w_overflow_nxt = 1'b1;
                        // Overwrite mode pushes the oldest entry out, so the
                        // read side advances with the write side.
                        if (w_overwrite) begin
                            w_write_addr_nxt = r_write_addr + c_ptr_one;
                            w_read_addr_nxt  = r_read_addr + c_ptr_one;
                        end
                    end
                end
                EV_READ: begin
                    if (!w_empty) begin
                        w_read_addr_nxt = r_read_addr + c_ptr_one;
                        w_level_nxt     = r_level - c_lvl_one;
                    end else begin
                        w_underflow_nxt = 1'b1;
                    end
                end
                EV_BOTH: begin
                    w_write_addr_nxt = r_write_addr + c_ptr_one;
                    if (w_empty) begin
                        // Nothing to read yet: keep the write, reject the read.
                        w_level_nxt     = c_lvl_one;
                        w_underflow_nxt = 1'b1;
                    end else begin
                        w_read_addr_nxt = r_read_addr + c_ptr_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_addr <= '0;
            r_read_addr  <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_write_addr <= w_write_addr_nxt;
            r_read_addr  <= w_read_addr_nxt;
            r_level      <= w_level_nxt;
            r_overflow   <= w_overflow_nxt;
            r_underflow  <= w_underflow_nxt;
        end
    end

    sat_counter #(
        .WIDTH (DROP_COUNT_W)
    ) u_drop_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_drop),
        .clear (flush),
        .count (drop_count)
    );

    assign write_addr  = r_write_addr;
    assign read_addr   = r_read_addr;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_level >= c_almost_full);

endmodule : ringbuffer_level
`default_nettype wire

// File: tb/tb_ringbuffer_level.sv
`default_nettype none
// ============================================================================
// Module      : tb_ringbuffer_level
// Description : Drives one stimulus stream into two ringbuffer_level
//               instances (BITS=3, ALMOST_FULL=6), one dropping writes when
//               full and one overwriting, and compares every output against
//               an occupancy model built from write/read totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ringbuffer_level;

    localparam int c_DEPTH = 8;
    localparam int c_AF    = 6;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic reset = 1'b1;
    logic write_done = 1'b0;
    logic read_done = 1'b0;
    logic flush = 1'b0;

    logic [2:0] wa0, ra0, wa1, ra1;
    logic [3:0] lv0, lv1;
    logic       em0, fu0, af0, ov0, un0;
    logic       em1, fu1, af1, ov1, un1;
    logic [7:0] dc0, dc1;

    int checks = 0;
    int passes = 0;

    // Model: occupancy plus lifetime totals of slots written and slots freed.
    int m_lvl[2];
    int m_wcnt[2];
    int m_rcnt[2];
    int m_drop[2];
    bit m_ovf[2];
    bit m_unf[2];
    bit m_ow[2];

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    ringbuffer_level #(.BITS(3), .ALMOST_FULL(c_AF), .OVERWRITE(0)) u_drop (
        .clk(clk), .reset(reset), .write_done(write_done), .read_done(read_done),
        .flush(flush), .write_addr(wa0), .read_addr(ra0), .level(lv0),
        .empty(em0), .full(fu0), .almost_full(af0), .overflow(ov0),
        .underflow(un0), .drop_count(dc0)
    );

    ringbuffer_level #(.BITS(3), .ALMOST_FULL(c_AF), .OVERWRITE(1)) u_ovw (
        .clk(clk), .reset(reset), .write_done(write_done), .read_done(read_done),
        .flush(flush), .write_addr(wa1), .read_addr(ra1), .level(lv1),
        .empty(em1), .full(fu1), .almost_full(af1), .overflow(ov1),
        .underflow(un1), .drop_count(dc1)
    );

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 0; m_wcnt[k] = 0; m_rcnt[k] = 0;
            m_drop[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
    endtask

    task automatic model_step(input bit w, input bit r, input bit f);
        for (int k = 0; k < 2; k++) begin
            if (f) begin
                m_lvl[k] = 0; m_wcnt[k] = 0; m_rcnt[k] = 0;
                m_drop[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (w && r) begin
                m_wcnt[k]++;
                if (m_lvl[k] == 0) begin
                    m_lvl[k] = 1;
                    m_unf[k] = 1;
                end else begin
                    m_rcnt[k]++;
                end
            end else if (w) begin
                if (m_lvl[k] < c_DEPTH) begin
                    m_wcnt[k]++;
                    m_lvl[k]++;
                end else begin
                    m_ovf[k] = 1;
                    if (m_drop[k] < 255) m_drop[k]++;
                    if (m_ow[k]) begin
                        m_wcnt[k]++;
                        m_rcnt[k]++;
                    end
                end
            end else if (r) begin
                if (m_lvl[k] > 0) begin
                    m_rcnt[k]++;
                    m_lvl[k]--;
                end else begin
                    m_unf[k] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_inst(input int k,
                              input logic [2:0] wa, input logic [2:0] ra,
                              input logic [3:0] lv, input logic em, input logic fu,
                              input logic af, input logic ov, input logic un,
                              input logic [7:0] dc);
        string p;
        p = $sformatf("ow%0d.", k);
        chk({p, "write_addr"},  32'(wa), 32'(m_wcnt[k] % c_DEPTH));
        chk({p, "read_addr"},   32'(ra), 32'(m_rcnt[k] % c_DEPTH));
        chk({p, "level"},       32'(lv), 32'(m_lvl[k]));
        chk({p, "empty"},       32'(em), 32'(m_lvl[k] == 0));
        chk({p, "full"},        32'(fu), 32'(m_lvl[k] == c_DEPTH));
        chk({p, "almost_full"}, 32'(af), 32'(m_lvl[k] >= c_AF));
        chk({p, "overflow"},    32'(ov), 32'(m_ovf[k]));
        chk({p, "underflow"},   32'(un), 32'(m_unf[k]));
        chk({p, "drop_count"},  32'(dc), 32'(m_drop[k]));
    endtask

    task automatic check_all();
        check_inst(0, wa0, ra0, lv0, em0, fu0, af0, ov0, un0, dc0);
        check_inst(1, wa1, ra1, lv1, em1, fu1, af1, ov1, un1, dc1);
    endtask

    // Apply one cycle of strobes, advance the model, sample 1 ns after the edge.
    task automatic step(input bit w, input bit r, input bit f, input bit do_check);
        write_done = w;
        read_done  = r;
        flush      = f;
        @(posedge clk);
        model_step(w, r, f);
        #1;
        write_done = 1'b0;
        read_done  = 1'b0;
        flush      = 1'b0;
        if (do_check) check_all();
    endtask

    initial begin
        m_ow[0] = 1'b0;
        m_ow[1] = 1'b1;
        model_clear();

        // Reset pulse with the clock stopped.
        #2 reset = 1'b0;
        #1 check_all();
        reset = 1'b1;
        #2 clk_en = 1'b1;
        @(negedge clk);

        // Nine writes: the ninth hits a full buffer in both modes.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ow0.wa_after_9", 32'(wa0), 32'd0);
        chk("ow1.wa_after_9", 32'(wa1), 32'd1);
        chk("ow1.ra_after_9", 32'(ra1), 32'd1);

        // Fill, then simultaneous write+read while full.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("ow0.wa_full_both", 32'(wa0), 32'd3);
        chk("ow0.ra_full_both", 32'(ra0), 32'd3);

        // Simultaneous write+read on an empty buffer.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("ow0.level_empty_both", 32'(lv0), 32'd1);
        // Lone read on empty after draining.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        // Saturate the drop counter, then flush together with a write.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all();
        chk("ow0.drop_sat", 32'(dc0), 32'd255);
        step(1'b1, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        write_done = 1'b1;
        #2 reset = 1'b0;
        model_clear();
        #1 check_all();
        @(posedge clk);
        @(posedge clk);
        #1 check_all();
        #3 reset = 1'b1;
        write_done = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ow0.wa_after_reset", 32'(wa0), 32'd2);
        chk("ow0.lv_after_reset", 32'(lv0), 32'd2);

        // Random traffic, alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 600; i++) begin
            bit w, r, f;
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(99) < bias);
            r = ($urandom_range(99) < (100 - bias));
            f = ($urandom_range(63) == 0);
            step(w, r, f, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_ringbuffer_level
`default_nettype wire

// File: doc/ringbuffer_level.md
RINGBUFFER_LEVEL -- requirements
Module: ringbuffer_level

Interface
REQ-001 SHALL have parameter BITS, default 7: address width; depth = 2**BITS entries.
REQ-002 SHALL have parameter ALMOST_FULL, default 2**BITS-4: level at or above which almost_full asserts.
REQ-003 SHALL have parameter OVERWRITE, default 0: 0 = drop write when full, 1 = overwrite oldest entry.
REQ-004 SHALL have ports as follows; one clock, reset asynchronous active-low:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  write_done  in  1  one-cycle strobe: one entry written at write_addr
  read_done  in  1  one-cycle strobe: one entry consumed at read_addr
  flush  in  1  synchronous clear of buffer state
  write_addr  out  BITS  next slot to write
  read_addr  out  BITS  oldest valid slot
  level  out  BITS+1  number of valid entries, 0..2**BITS
  empty  out  1  level == 0
  full  out  1  level == 2**BITS
  almost_full  out  1  level >= ALMOST_FULL
  overflow  out  1  sticky: a write arrived while full
  underflow  out  1  sticky: a read arrived while empty
  drop_count  out  8  saturating count of writes that hit a full buffer

Function
REQ-005 SHALL sample all strobes on rising clk; a strobe held N cycles counts as N events.
REQ-006 SHALL register write_addr, read_addr, level, overflow, underflow and drop_count; empty/full/almost_full are combinational decodes of registered level (valid in the cycle after the edge, no extra latency).
REQ-007 SHALL wrap both pointers modulo 2**BITS with no special-casing (2**BITS-1 -> 0).
REQ-008 SHALL, on write_done only and not full, increment write_addr and level.
REQ-009 SHALL, on read_done only and not empty, increment read_addr and decrement level.
REQ-010 SHALL, on write_done and read_done together with 0 < level < 2**BITS, increment both pointers; level unchanged.
REQ-011 SHALL, on write_done and read_done together while empty, accept the write, ignore the read (level becomes 1), and set underflow.
REQ-012 SHALL, on write_done and read_done together while full, accept both; level unchanged; overflow not set.
REQ-013 SHALL, on read_done alone while empty, leave pointers and level unchanged and set underflow.
REQ-014 SHALL, on write_done alone while full with OVERWRITE=0, leave pointers and level unchanged, set overflow, increment drop_count.
REQ-015 SHALL, on write_done alone while full with OVERWRITE=1, increment write_addr and read_addr, keep level at 2**BITS, set overflow, increment drop_count.
REQ-016 SHALL saturate drop_count at 255.
REQ-017 SHALL, on flush, set pointers and level to 0 and clear overflow, underflow and drop_count; flush overrides write_done/read_done in the same cycle.

Reset
REQ-018 SHALL, while reset is low, force write_addr=0, read_addr=0, level=0, overflow=0, underflow=0, drop_count=0, hence empty=1, full=0, almost_full=0 (almost_full=1 if ALMOST_FULL=0).
REQ-019 SHALL act on reset asynchronously, independent of clk, including mid-burst; strobes during reset are discarded.
REQ-020 SHALL resume normal counting on the first rising clk after reset deasserts.

Structure
REQ-021 SHALL take drop-counter width (8) and the OVERWRITE mode encodings from the shared ringbuffer constants package; BITS and ALMOST_FULL stay module parameters.
REQ-022 SHALL implement drop_count as one sub-module, sat_counter (width parameter, inc, clear, async active-low reset); the rest is flat.

Verification (BITS=3, ALMOST_FULL=6 unless stated)
REQ-023 Reset pulse low 1 ns, no clock -> write_addr=0, read_addr=0, level=0, empty=1, full=0, overflow=0.
REQ-024 9 write strobes, OVERWRITE=0 -> level=8, full=1, almost_full=1 after 6th, write_addr=0, overflow=1, drop_count=1.
REQ-025 Same 9 writes, OVERWRITE=1 -> level=8, write_addr=1, read_addr=1, overflow=1, drop_count=1.
REQ-026 Fill to 8, then 3 cycles of simultaneous write+read -> level=8, write_addr=3, read_addr=3, overflow=0; then from empty, simultaneous write+read -> level=1, underflow=1.
REQ-027 300 writes to full buffer -> drop_count=255; flush asserted with write_done same cycle -> level=0, pointers 0, drop_count=0, overflow=0.
REQ-028 Reset asserted mid-burst of 5 writes (after 3) -> outputs 0 immediately without clk edge; 2 writes after release -> write_addr=2, level=2.
